// File: rtl/alu_div_seq.sv
// Sequential unsigned restoring divider: A / B -> Q, R, one quotient bit per clock, MSB first.
// Flags follow the ALU's result semantics so status display logic can be shared.
module alu_div_seq #(
    parameter int unsigned WA = 4,
    parameter int unsigned WB = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [WA-1:0] A,
    input  logic [WB-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [WA-1:0] Q,
    output logic [WB-1:0] R,
    output logic          Z,
    output logic          N,
    output logic          C,
    output logic          V
);

    localparam int unsigned CW = (WA > 1) ? $clog2(WA) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [WA-1:0] dvd;
    logic [WB-1:0] div;
    logic [WB:0]   acc;
    logic [CW-1:0] cnt;

    logic [WB:0]   acc_sh;
    logic          ge;
    logic [WB:0]   acc_nx;
    logic [WA-1:0] q_nx;

    // One restoring step; dvd doubles as the quotient register as bits shift in.
    always_comb begin
        acc_sh = '0;
        ge     = 1'b0;
        acc_nx = '0;
        q_nx   = '0;
        acc_sh = (acc << 1) | (WB+1)'(dvd[WA-1]);
        ge     = (acc_sh >= {1'b0, div});
        acc_nx = ge ? (acc_sh - {1'b0, div}) : acc_sh;
        q_nx   = {dvd[WA-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            dvd   <= '0;
            div   <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            Z     <= 1'b0;
            N     <= 1'b0;
            C     <= 1'b0;
            V     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd   <= A;
                        div   <= B;
                        acc   <= '0;
                        cnt   <= CW'(WA - 1);
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc_nx;
                    dvd <= q_nx;
                    if (cnt == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Divide-by-zero forces an all-ones quotient; flags follow the forced value.
                        if (div == '0) begin
                            Q <= '1;
                            R <= '0;
                            Z <= 1'b0;
                            N <= 1'b1;
                            C <= 1'b0;
                            V <= 1'b1;
                        end else begin
                            Q <= q_nx;
                            R <= acc_nx[WB-1:0];
                            Z <= (q_nx == '0);
                            N <= q_nx[WA-1];
                            C <= (acc_nx[WB-1:0] != '0);
                            V <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: expected results queued at start, compared on each done pulse.
module tb_alu_div_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [1:0] B;
    logic       busy;
    logic       done;
    logic [3:0] Q;
    logic [1:0] R;
    logic       Z;
    logic       N;
    logic       C;
    logic       V;

    typedef struct packed {
        logic [3:0] q;
        logic [1:0] r;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_done  = 0;
    int   n_ops   = 0;

    alu_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .Z     (Z),
        .N     (N),
        .C     (C),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = 4'hF;
            e.r = 2'd0;
            e.v = 1'b1;
        end else begin
            e.q = 4'(a / b);
            e.r = 2'(a % b);
            e.v = 1'b0;
        end
        e.z = (e.q == 4'd0);
        e.n = e.q[3];
        e.c = (e.r != 2'd0);
        return e;
    endfunction

    // Result checker: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("Q", int'(Q), int'(e.q));
                check("R", int'(R), int'(e.r));
                check("Z", int'(Z), int'(e.z));
                check("N", int'(N), int'(e.n));
                check("C", int'(C), int'(e.c));
                check("V", int'(V), int'(e.v));
            end
        end
    end

    // Drives one op starting in the current cycle (cycle 0); returns in cycle WA+2.
    task automatic do_op(input int a, input int b, input bit poke);
        A     = 4'(a);
        B     = 2'(b);
        start = 1'b1;
        exp_q.push_back(model(a, b));
        n_ops++;
        tick();
        start = 1'b0;
        A     = 4'(a ^ 15);
        B     = 2'(b ^ 3);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            check("busy_run", int'(busy), 1);
            check("done_run", int'(done), 0);
            if (poke && cyc == 2) begin
                start = 1'b1;
                A     = 4'd7;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("done_pulse", int'(done), 1);
        check("busy_done", int'(busy), 0);
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        check("done_low", int'(done), 0);
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;
        rst_n = 1'b0;
        start = 1'b0;
        A     = 4'd0;
        B     = 2'd0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_Q", int'(Q), 0);
        check("rst_R", int'(R), 0);
        check("rst_flags", int'({Z, N, C, V}), 0);
        rst_n = 1'b1;
        tick();

        do_op(13, 3, 1'b0);
        do_op(12, 2, 1'b0);
        do_op(1, 3, 1'b0);
        do_op(15, 1, 1'b0);
        do_op(9, 0, 1'b0);
        // Starts in cycles 2 and 5 are ignored; the next op begins in cycle 6.
        do_op(13, 3, 1'b1);
        do_op(6, 2, 1'b0);

        // Reset in cycle 3 discards the op and clears outputs; no done follows.
        A     = 4'd14;
        B     = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_Q", int'(Q), 0);
        check("mid_rst_R", int'(R), 0);
        check("mid_rst_flags", int'({Z, N, C, V}), 0);
        done_before = n_done;
        for (int i = 0; i < 8; i++) tick();
        check("no_done_after_rst", n_done, done_before);

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 4; b++) begin
                do_op(a, b, 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) tick();

        check("done_count", n_done, n_ops);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
